wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-port arbiter for the 32×32 register file. Two writeback sources, ALU results and load data from the LSU, compete for the register file's single write port (WE3/AD3/WD3). The block grants one source per cycle with valid/ready handshakes and registers the winning write. It also exports a per-register pending mask so the hazard logic can stall reads of registers whose write has not yet landed.

## Interface
Parameters:
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_rd  in  AW  LSU destination register
- lsu_data  in  DW  load data
- we3  out  1  register file write enable
- ad3  out  AW  register file write address
- wd3  out  DW  register file write data
- pending  out  32  bit r high while a write to register r sits in the output stage
- last_grant  out  1  source of the last accepted request: 0 = ALU, 1 = LSU

## Operation
- A request is accepted on a rising edge when valid and ready are both high.
- Ready signals are combinational. The losing source's ready is low; the winner's ready equals its valid.
- Only one source sees ready high in any cycle.
- Only one source valid: that source is granted.
- Both valid: priority follows the configured policy (see Configuration).
- Holding rules:
  - Requester data and rd must stay stable while valid is high and ready is low.
  - Valid must not drop before acceptance.
- Accepted request updates the output stage:
  - ad3 ← rd, wd3 ← data, last_grant ← source.
  - we3 ← 1, unless rd == 0; x0 writes are consumed with we3 ← 0.
- No request accepted: we3 ← 0. ad3 and wd3 hold their previous values.
- pending is combinational: one-hot of ad3 when we3 == 1, otherwise all zeros. Bit 0 is never set.
- Both sources target the same rd in the same cycle: they serialise in grant order. The later grant overwrites the earlier one in the register file. No merging.
- Reset, including mid-transaction: an in-flight output-stage write is discarded, and any unaccepted requester transaction remains the requester's responsibility. Outputs after reset:
  - we3 = 0, ad3 = 0, wd3 = 0, last_grant = 0, pending = 0.

## Timing
- Latency: accept at edge N → we3/ad3/wd3 valid in cycle N..N+1. The register file commits at edge N+1.
- Throughput: one write per cycle. Back-to-back grants are allowed, including to the same source.
- Under contention, the losing source waits at least one cycle.
- Round-robin worst-case wait is 1 cycle.
- No combinational path from we3/ad3/wd3 back to ready.
- Ready depends only on the current valids and the last_grant register.

## Configuration
- WB_ARB_RR_EN defined: round-robin. When both are valid, the source opposite to last_grant wins, so after reset (last_grant = 0) the LSU wins first.
- WB_ARB_RR_EN undefined: fixed priority, LSU always beats ALU.
  - last_grant is still tracked and output.
  - ALU starvation under continuous LSU traffic is permitted in this mode.

## Structure
- Shared package wb_pkg:
  - typedef wb_src_e {WB_SRC_ALU = 0, WB_SRC_LSU = 1}
  - typedef wb_req_t {rd, data}
  - constant REG_ZERO = 0
- Sub-module wb_rr_pick holds the grant decision: inputs are two valids and last_grant, outputs are two grant bits.
- The output register stage and pending decode live in wb_arbiter.

## Test plan
- Reset: hold rst_n low mid-stream with we3 = 1 → we3, ad3, wd3, pending, last_grant all 0 immediately. First grant after release is the LSU under RR.
- Single source: ALU rd = 5, data = 0xDEADBEEF for one cycle → alu_ready = 1. Next cycle: we3 = 1, ad3 = 5, wd3 = 0xDEADBEEF, pending = 0x00000020.
- Contention, RR build: both valid for 4 cycles (ALU rd = 1, LSU rd = 2) → grants alternate LSU, ALU, LSU, ALU; ad3 sequence 2, 1, 2, 1.
- Contention, non-RR build: same stimulus → LSU wins all 4 cycles and alu_ready stays 0.
- x0 write: LSU rd = 0, data = 0x12345678 → lsu_ready = 1. Next cycle: we3 = 0, pending = 0, last_grant = 1.
- Same rd collision: ALU and LSU both target rd = 7 with data 0xA and 0xB (RR from reset) → register 7 holds 0xB after the first write and 0xA after the second.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_pkg;

   localparam int WB_AW    = 5;
   localparam int WB_DW    = 32;
   localparam int REG_ZERO = 0;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [WB_AW-1:0] rd;
      logic [WB_DW-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Grant decision for the two writeback sources.
// Round-robin when WB_ARB_RR_EN is defined, otherwise fixed LSU priority.
module wb_rr_pick
   import wb_pkg::*;
(
   input  logic alu_valid_i,
   input  logic lsu_valid_i,
   input  logic last_grant_i,
   output logic alu_gnt_o,
   output logic lsu_gnt_o
);

   logic lsu_wins_tie;

`ifdef WB_ARB_RR_EN
   // On a tie the source that did not win last time goes first.
   assign lsu_wins_tie = (last_grant_i == WB_SRC_ALU);
`else
   assign lsu_wins_tie = 1'b1;
`endif

   always_comb begin
      alu_gnt_o = 1'b0;
      lsu_gnt_o = 1'b0;
      if (alu_valid_i && lsu_valid_i) begin
         lsu_gnt_o = lsu_wins_tie;
         alu_gnt_o = !lsu_wins_tie;
      end else begin
         alu_gnt_o = alu_valid_i;
         lsu_gnt_o = lsu_valid_i;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: picks ALU or LSU writeback, registers the
// winning write and exports a pending mask. Policy selected by WB_ARB_RR_EN.
//
// Handshake: a request transfers on a rising edge where valid && ready. Ready is
// combinational from the two valids and last_grant only; at most one ready is high.
// A requester holds rd/data stable and keeps valid high until it is accepted.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int AW = WB_AW,
   parameter int DW = WB_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [AW-1:0] alu_rd,
   input  logic [DW-1:0] alu_data,
   input  logic          lsu_valid,
   output logic          lsu_ready,
   input  logic [AW-1:0] lsu_rd,
   input  logic [DW-1:0] lsu_data,
   output logic          we3,
   output logic [AW-1:0] ad3,
   output logic [DW-1:0] wd3,
   output logic [31:0]   pending,
   output logic          last_grant
);

   logic          we3_q, we3_d;
   logic [AW-1:0] ad3_q, ad3_d;
   logic [DW-1:0] wd3_q, wd3_d;
   logic          last_grant_q, last_grant_d;
   logic          alu_gnt, lsu_gnt;
   wb_src_e       src;
   logic [AW-1:0] sel_rd;
   logic [DW-1:0] sel_data;

   wb_rr_pick u_pick (
      .alu_valid_i  (alu_valid),
      .lsu_valid_i  (lsu_valid),
      .last_grant_i (last_grant_q),
      .alu_gnt_o    (alu_gnt),
      .lsu_gnt_o    (lsu_gnt)
   );

   assign alu_ready = alu_gnt;
   assign lsu_ready = lsu_gnt;

   assign src      = lsu_gnt ? WB_SRC_LSU : WB_SRC_ALU;
   assign sel_rd   = lsu_gnt ? lsu_rd   : alu_rd;
   assign sel_data = lsu_gnt ? lsu_data : alu_data;

   always_comb begin
      we3_d        = 1'b0;
      ad3_d        = ad3_q;
      wd3_d        = wd3_q;
      last_grant_d = last_grant_q;
      if (alu_gnt || lsu_gnt) begin
         // Writes to x0 are consumed but never reach the register file.
         we3_d        = (sel_rd != AW'(REG_ZERO));
         ad3_d        = sel_rd;
         wd3_d        = sel_data;
         last_grant_d = src;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3_q        <= 1'b0;
         ad3_q        <= '0;
         wd3_q        <= '0;
         last_grant_q <= 1'b0;
      end else begin
         we3_q        <= we3_d;
         ad3_q        <= ad3_d;
         wd3_q        <= wd3_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      pending = '0;
      for (int r = 0; r < 32; r++) begin
         pending[r] = we3_q && (ad3_q == AW'(r));
      end
   end

   assign we3        = we3_q;
   assign ad3        = ad3_q;
   assign wd3        = wd3_q;
   assign last_grant = last_grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expectations follow WB_ARB_RR_EN.
module tb_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        alu_valid, lsu_valid;
   logic        alu_ready, lsu_ready;
   logic [4:0]  alu_rd, lsu_rd;
   logic [31:0] alu_data, lsu_data;
   logic        we3;
   logic [4:0]  ad3;
   logic [31:0] wd3;
   logic [31:0] pending;
   logic        last_grant;

   logic [31:0] rf [32];
   int          total = 0;
   int          bad = 0;

   wb_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .we3        (we3),
      .ad3        (ad3),
      .wd3        (wd3),
      .pending    (pending),
      .last_grant (last_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: commits the output stage on each rising edge.
   always @(posedge clk) begin
      if (we3) rf[ad3] <= wd3;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_we3"}, {31'd0, we3}, 32'd0);
      chk({tag, "_ad3"}, {27'd0, ad3}, 32'd0);
      chk({tag, "_wd3"}, wd3, 32'd0);
      chk({tag, "_pending"}, pending, 32'd0);
      chk({tag, "_last_grant"}, {31'd0, last_grant}, 32'd0);
   endtask

   initial begin
      logic [3:0] lsu_win;
`ifdef WB_ARB_RR_EN
      lsu_win = 4'b0101;
`else
      lsu_win = 4'b1111;
`endif
      for (int r = 0; r < 32; r++) rf[r] = '0;
      idle();
      rst_n = 1'b0;
      #2;
      chk_reset_outputs("por");
      cyc();
      rst_n = 1'b1;
      cyc();

      // Single ALU write to r5
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      chk("alu_single_ready", {31'd0, alu_ready}, 32'd1);
      chk("alu_single_lsu_ready", {31'd0, lsu_ready}, 32'd0);
      cyc();
      idle();
      chk("alu_single_we3", {31'd0, we3}, 32'd1);
      chk("alu_single_ad3", {27'd0, ad3}, 32'd5);
      chk("alu_single_wd3", wd3, 32'hDEADBEEF);
      chk("alu_single_pending", pending, 32'h0000_0020);
      chk("alu_single_last_grant", {31'd0, last_grant}, 32'd0);
      cyc();
      chk("idle_we3", {31'd0, we3}, 32'd0);
      chk("idle_ad3_hold", {27'd0, ad3}, 32'd5);
      chk("idle_wd3_hold", wd3, 32'hDEADBEEF);
      chk("idle_pending", pending, 32'd0);
      chk("rf5_commit", rf[5], 32'hDEADBEEF);

      // LSU write to x0 is consumed without a register-file write
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h12345678;
      #1;
      chk("x0_lsu_ready", {31'd0, lsu_ready}, 32'd1);
      cyc();
      idle();
      chk("x0_we3", {31'd0, we3}, 32'd0);
      chk("x0_pending", pending, 32'd0);
      chk("x0_last_grant", {31'd0, last_grant}, 32'd1);

      // Mid-stream reset with a write sitting in the output stage
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
      cyc();
      idle();
      chk("prereset_we3", {31'd0, we3}, 32'd1);
      chk("prereset_pending", pending, 32'h0000_0008);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      cyc();
      rst_n = 1'b1;
      cyc();

      // Contention: both valid for four cycles
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("cont%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, lsu_win[i]});
         chk($sformatf("cont%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, !lsu_win[i]});
         cyc();
         chk($sformatf("cont%0d_ad3", i), {27'd0, ad3}, lsu_win[i] ? 32'd2 : 32'd1);
         chk($sformatf("cont%0d_wd3", i), wd3, lsu_win[i] ? 32'h22 : 32'h11);
         chk($sformatf("cont%0d_last_grant", i), {31'd0, last_grant}, {31'd0, lsu_win[i]});
      end
      idle();
      cyc();

      // Same-rd collision from reset: LSU lands first, ALU overwrites
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      rf[7] = 32'h0;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hB;
      #1;
      chk("coll_first_lsu_ready", {31'd0, lsu_ready}, 32'd1);
      cyc();
      lsu_valid = 1'b0;
      #1;
      chk("coll_second_alu_ready", {31'd0, alu_ready}, 32'd1);
      cyc();
      alu_valid = 1'b0;
      chk("coll_rf7_after_first", rf[7], 32'hB);
      chk("coll_pending", pending, 32'h0000_0080);
      cyc();
      chk("coll_rf7_after_second", rf[7], 32'hA);
      chk("coll_idle_we3", {31'd0, we3}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
